// File: rtl/jtframe_info_pkg.sv
// Shared types and constants for the system-info status scanner.
package jtframe_info_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    CAPTURE = 2'd2,
    SWAP    = 2'd3
  } state_t;

  // Entry 0 sits in the least significant byte.
  localparam logic [63:0] DEFAULT_ADDR_LIST = {
    8'h80, 8'h41, 8'h40, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00
  };

endpackage

// File: rtl/jtframe_info_scan_if.sv
// Status bus plus host read port of the info scanner.
interface jtframe_info_scan_if #(
  parameter int AW = 3
);

  logic [7:0]    st_addr;
  logic [7:0]    st_dout;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_dout;

  // The scanner owns st_addr and answers host reads.
  modport master (
    output st_addr,
    input  st_dout,
    input  rd_addr,
    output rd_dout
  );

  // System-info block and host side.
  modport slave (
    input  st_addr,
    output st_dout,
    output rd_addr,
    input  rd_dout
  );

endinterface

// File: rtl/jtframe_info_bank.sv
// Double-buffered snapshot file: the scanner fills the back bank while the host
// reads the front bank; a toggle swaps them atomically.
module jtframe_info_bank #(
  parameter int ENTRIES = 8,
  parameter int AW      = 3,
  parameter int IW      = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          toggle,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dout
);

  logic [7:0] mem [2][ENTRIES];
  logic       fsel;
  logic       bsel;
  logic [7:0] rd_word;

  assign bsel = ~fsel;

  // Addresses beyond the scanned list fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (rd_addr == AW'(i)) rd_word = mem[fsel][i];
    end
  end

  // NOTE: the banks are plain flops, so a synchronous clear of every word is
  // legal here; a RAM-mapped array could not be reset this way.
  always_ff @(posedge clk) begin
    if (clr) begin
      fsel    <= 1'b0;
      rd_dout <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < ENTRIES; i++) mem[b][i] <= '0;
      end
    end else begin
      // Uses fsel before the edge: a read in the swap cycle sees the old bank.
      rd_dout <= rd_word;
      if (toggle) fsel <= bsel;
      if (wr_en) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (wr_idx == IW'(i)) mem[bsel][i] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/jtframe_info_scan.sv
// Once-per-frame scheduler that walks the status bus and publishes a
// frame-consistent snapshot to a host read port.
module jtframe_info_scan
  import jtframe_info_pkg::*;
#(
  parameter int                     ENTRIES   = 8,
  parameter int                     AW        = 3,
  parameter int                     WAIT      = 2,
  parameter logic [ENTRIES*8-1:0]   ADDR_LIST = DEFAULT_ADDR_LIST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                LVBL,
  input  logic                en,
  jtframe_info_scan_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [7:0]          ovr_cnt
);

  localparam int IW = $clog2(ENTRIES);
  localparam int WW = (WAIT > 1) ? $clog2(WAIT) : 1;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [WW-1:0] cnt, cnt_nx;
  logic [7:0]    addr, addr_nx;
  logic          lvbl_l;
  logic          trig;
  logic          wr_en;
  logic          toggle;

  function automatic logic [7:0] list_entry(input int i);
    return ADDR_LIST[i*8 +: 8];
  endfunction

  assign trig        = lvbl_l & ~LVBL;
  assign bus.st_addr = addr;
  assign busy        = (state != IDLE);
  assign done        = (state == SWAP);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    addr_nx  = addr;
    wr_en    = 1'b0;
    toggle   = 1'b0;
    case (state)
      IDLE: begin
        if (trig && en) begin
          state_nx = SETUP;
          idx_nx   = '0;
          cnt_nx   = '0;
          addr_nx  = list_entry(0);
        end
      end
      SETUP: begin
        // Hold the address long enough for the registered bus to settle.
        if (cnt == WW'(WAIT - 1)) state_nx = CAPTURE;
        else                      cnt_nx   = cnt + 1'b1;
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (idx == IW'(ENTRIES - 1)) begin
          state_nx = SWAP;
        end else begin
          state_nx = SETUP;
          idx_nx   = idx + 1'b1;
          cnt_nx   = '0;
          addr_nx  = list_entry(int'(idx) + 1);
        end
      end
      SWAP: begin
        toggle   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      addr    <= '0;
      lvbl_l  <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      addr   <= addr_nx;
      lvbl_l <= LVBL;
      if (trig && busy && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

  jtframe_info_bank #(
    .ENTRIES (ENTRIES),
    .AW      (AW),
    .IW      (IW)
  ) u_bank (
    .clk     (clk),
    .clr     (rst),
    .wr_idx  (idx),
    .wr_data (bus.st_dout),
    .wr_en   (wr_en),
    .toggle  (toggle),
    .rd_addr (bus.rd_addr),
    .rd_dout (bus.rd_dout)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (WAIT >= 1 && ENTRIES >= 2 && ENTRIES <= 2**AW)
      else $error("jtframe_info_scan: illegal WAIT/ENTRIES/AW combination");
  end
`endif

endmodule

// File: tb/tb_jtframe_info_scan.sv
// Directed bench for jtframe_info_scan with a 1-cycle registered status-bus model.
module tb_jtframe_info_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       LVBL;
  logic       en;
  logic       busy;
  logic       done;
  logic [7:0] ovr_cnt;
  logic       model_inc = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_x [8] = '{8'h5A, 8'h5A, 8'h5B, 8'h58, 8'h59, 8'h1A, 8'h1B, 8'hDA};
  logic [7:0] exp_i [8] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h41, 8'h42, 8'h81};

  jtframe_info_scan_if #(.AW(3)) bus ();

  jtframe_info_scan #(
    .ENTRIES (8),
    .AW      (3),
    .WAIT    (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .LVBL    (LVBL),
    .en      (en),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .ovr_cnt (ovr_cnt)
  );

  always #5 clk = ~clk;

  // Status bus: data follows the address with one registered cycle.
  always @(posedge clk)
    bus.st_dout <= model_inc ? bus.st_addr + 8'd1 : bus.st_addr ^ 8'h5A;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input logic [2:0] a, input logic [7:0] e, input string tag);
    bus.rd_addr = a;
    tick();
    check($sformatf("%s[%0d]", tag, a), {24'd0, bus.rd_dout}, {24'd0, e});
  endtask

  // Falls LVBL and runs until busy drops; returns busy cycles and done pulses.
  task automatic run_scan(input bit drop_en, output int nb, output int nd);
    nb   = 0;
    nd   = 0;
    LVBL = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 0 && drop_en) en = 1'b0;
      if (busy) nb++;
      if (done) nd++;
      if (!busy) break;
    end
    LVBL = 1'b1;
    tick();
  endtask

  initial begin
    int nb;
    int nd;
    int seen;

    rst         = 1'b1;
    LVBL        = 1'b1;
    en          = 1'b0;
    bus.rd_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy",    {31'd0, busy},           32'd0);
    check("reset_done",    {31'd0, done},           32'd0);
    check("reset_ovr",     {24'd0, ovr_cnt},        32'd0);
    check("reset_st_addr", {24'd0, bus.st_addr},    32'd0);
    check("reset_rd_dout", {24'd0, bus.rd_dout},    32'd0);

    // Frame 1: XOR model.
    en = 1'b1;
    run_scan(1'b0, nb, nd);
    check("scan1_busy_cycles", nb, 32'd25);
    check("scan1_done_pulses", nd, 32'd1);
    check("scan1_st_addr_hold", {24'd0, bus.st_addr}, 32'h80);
    for (int a = 0; a < 8; a++) read_chk(3'(a), exp_x[a], "scan1_read");

    // Frame 2: increment model; probe the read around the swap cycle.
    model_inc   = 1'b1;
    bus.rd_addr = 3'd2;
    LVBL        = 1'b0;
    seen        = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("scan2_done_seen", seen, 32'd1);
    check("scan2_read_before_swap", {24'd0, bus.rd_dout}, 32'h5B);
    bus.rd_addr = 3'd7;
    tick();
    check("read_in_swap_cycle_old", {24'd0, bus.rd_dout}, 32'hDA);
    tick();
    check("read_after_swap_new", {24'd0, bus.rd_dout}, 32'h81);
    check("scan2_idle_after", {31'd0, busy}, 32'd0);
    LVBL = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) read_chk(3'(a), exp_i[a], "scan2_read");

    // Three lost triggers inside one scan.
    nd   = 0;
    LVBL = 1'b0;
    tick();
    check("ovr_scan_started", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      LVBL = 1'b1;
      tick();
      if (done) nd++;
      LVBL = 1'b0;
      tick();
      if (done) nd++;
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) nd++;
      if (!busy) break;
    end
    check("ovr_count_3", {24'd0, ovr_cnt}, 32'd3);
    check("ovr_single_done", nd, 32'd1);
    LVBL = 1'b1;
    tick();

    // Trigger with en low: ignored entirely.
    en   = 1'b0;
    LVBL = 1'b0;
    nb   = 0;
    repeat (5) begin
      tick();
      if (busy) nb++;
    end
    check("en0_no_busy", nb, 32'd0);
    check("en0_st_addr_kept", {24'd0, bus.st_addr}, 32'h80);
    check("en0_ovr_kept", {24'd0, ovr_cnt}, 32'd3);
    LVBL = 1'b1;
    tick();

    // en dropped right after the scan starts.
    en = 1'b1;
    run_scan(1'b1, nb, nd);
    check("en_drop_busy_cycles", nb, 32'd25);
    check("en_drop_done_pulses", nd, 32'd1);
    en = 1'b1;

    // A trigger every other cycle for many frames saturates the counter.
    for (int i = 0; i < 400; i++) begin
      LVBL = 1'b0;
      tick();
      LVBL = 1'b1;
      tick();
    end
    check("ovr_saturated", {24'd0, ovr_cnt}, 32'hFF);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) break;
    end

    // Reset in the middle of a scan.
    LVBL = 1'b0;
    repeat (10) tick();
    check("rst_mid_scan_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) read_chk(3'(a), 8'h00, "rst_read_zero");
    check("rst_ovr_cleared", {24'd0, ovr_cnt}, 32'd0);
    LVBL = 1'b1;
    tick();
    run_scan(1'b0, nb, nd);
    check("post_rst_busy_cycles", nb, 32'd25);
    check("post_rst_done_pulses", nd, 32'd1);
    for (int a = 0; a < 8; a++) read_chk(3'(a), exp_i[a], "post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
